// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA ship/grid drawers.
// Slot k of a 64-bit position vector holds X at bit 3+8k and Y at bit 7+8k (4 bits each).
package vga_pkg;

    typedef logic [7:0] rgb332_t;

    localparam int COORD_W     = 4;
    localparam int SLOT_STRIDE = 8;
    localparam int SLOT_BASE   = 3;
    localparam int MAX_SLOTS   = 7;
    localparam int GRID_MAX    = 15;

    typedef logic [COORD_W-1:0] coord_t;

    function automatic coord_t slot_x(input logic [63:0] vec, input int k);
        return vec[SLOT_BASE + SLOT_STRIDE*k +: COORD_W];
    endfunction

    function automatic coord_t slot_y(input logic [63:0] vec, input int k);
        return vec[SLOT_BASE + COORD_W + SLOT_STRIDE*k +: COORD_W];
    endfunction

endpackage

// File: rtl/vga_desenho_embarcacao_if.sv
// Pixel-scan inputs and colour outputs of the ship drawer.
// master = scan/timing side, slave = drawer; all signals are single-cycle, no handshake.
interface vga_desenho_embarcacao_if;
    import vga_pkg::*;

    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic        frame_start;
    logic [63:0] posicoesEmbarcacao;
    logic        ship_pixel;
    rgb332_t     rgb;
    logic        pixel_valid;

    modport master (
        output pixel_x, pixel_y, video_on, frame_start, posicoesEmbarcacao,
        input  ship_pixel, rgb, pixel_valid
    );

    modport slave (
        input  pixel_x, pixel_y, video_on, frame_start, posicoesEmbarcacao,
        output ship_pixel, rgb, pixel_valid
    );
endinterface

// File: rtl/vga_celula_pixel.sv
// Registered pixel -> grid cell mapping (1-based column/row, in-grid and cell-outline flags).
// Shared by the ship, cursor and hit-marker drawers.
module vga_celula_pixel
    import vga_pkg::*;
#(
    parameter int CELL_LOG2 = 5,
    parameter int GRID_X0   = 64,
    parameter int GRID_Y0   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pixel_x_i,
    input  logic [9:0] pixel_y_i,
    input  logic       video_on_i,
    output coord_t     cell_col_o,
    output coord_t     cell_row_o,
    output logic       in_grid_o,
    output logic       edge_o,
    output logic       video_on_o
);

    logic [10:0]          rel_x, rel_y;
    logic [10:0]          col_full, row_full;
    logic [CELL_LOG2-1:0] off_x, off_y;

    coord_t cell_col_d, cell_col_q;
    coord_t cell_row_d, cell_row_q;
    logic   in_grid_d, in_grid_q;
    logic   edge_d, edge_q;
    logic   video_on_q;

    // Bit 10 of the 11-bit difference is the sign: pixel is left of / above the grid.
    always_comb begin
        rel_x      = {1'b0, pixel_x_i} - 11'(GRID_X0);
        rel_y      = {1'b0, pixel_y_i} - 11'(GRID_Y0);
        col_full   = (rel_x >> CELL_LOG2) + 11'd1;
        row_full   = (rel_y >> CELL_LOG2) + 11'd1;
        off_x      = rel_x[CELL_LOG2-1:0];
        off_y      = rel_y[CELL_LOG2-1:0];
        cell_col_d = col_full[COORD_W-1:0];
        cell_row_d = row_full[COORD_W-1:0];
        in_grid_d  = !rel_x[10] && !rel_y[10]
                     && (col_full <= 11'(GRID_MAX)) && (row_full <= 11'(GRID_MAX));
        edge_d     = (off_x == '0) || (&off_x) || (off_y == '0) || (&off_y);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cell_col_q <= '0;
            cell_row_q <= '0;
            in_grid_q  <= 1'b0;
            edge_q     <= 1'b0;
            video_on_q <= 1'b0;
        end else begin
            cell_col_q <= cell_col_d;
            cell_row_q <= cell_row_d;
            in_grid_q  <= in_grid_d;
            edge_q     <= edge_d;
            video_on_q <= video_on_i;
        end
    end

    assign cell_col_o = cell_col_q;
    assign cell_row_o = cell_row_q;
    assign in_grid_o  = in_grid_q;
    assign edge_o     = edge_q;
    assign video_on_o = video_on_q;

endmodule

// File: rtl/vga_desenho_embarcacao.sv
// Ship drawer: 2-cycle pipeline deciding per scanned pixel whether it lies in an occupied ship cell.
// Optional VGA_EMBARCACAO_BLINK_EN hides the ship for 32 of every 64 frames.
module vga_desenho_embarcacao
    import vga_pkg::*;
#(
    parameter int      N_CELLS    = 1,
    parameter int      CELL_LOG2  = 5,
    parameter int      GRID_X0    = 64,
    parameter int      GRID_Y0    = 0,
    parameter rgb332_t SHIP_COLOR = 8'b100_100_10,
    parameter rgb332_t EDGE_COLOR = 8'b010_010_01
) (
    input  logic                      clk,
    input  logic                      reset,
    vga_desenho_embarcacao_if.slave   bus
);

    // Captured once per frame so a mid-frame move cannot tear the drawn ship.
    logic [63:0] pos_d, pos_q;

    coord_t cell_col, cell_row;
    logic   in_grid, edge_s1, video_on_d1;

    logic    ship_d, ship_q;
    rgb332_t rgb_d, rgb_q;
    logic    valid_d, valid_q;
    logic    match, hide, hit;
    coord_t  sx, sy;

    logic unused_bits;
    assign unused_bits = ^{pos_q[2:0], pos_q[63:59]};

    vga_celula_pixel #(
        .CELL_LOG2 (CELL_LOG2),
        .GRID_X0   (GRID_X0),
        .GRID_Y0   (GRID_Y0)
    ) u_celula (
        .clk        (clk),
        .reset      (reset),
        .pixel_x_i  (bus.pixel_x),
        .pixel_y_i  (bus.pixel_y),
        .video_on_i (bus.video_on),
        .cell_col_o (cell_col),
        .cell_row_o (cell_row),
        .in_grid_o  (in_grid),
        .edge_o     (edge_s1),
        .video_on_o (video_on_d1)
    );

    assign pos_d = bus.frame_start ? bus.posicoesEmbarcacao : pos_q;

`ifdef VGA_EMBARCACAO_BLINK_EN
    logic [5:0] blink_d, blink_q;

    assign blink_d = bus.frame_start ? blink_q + 6'd1 : blink_q;
    assign hide    = blink_q[5];

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_d;
        end
    end
`else
    assign hide = 1'b0;
`endif

    always_comb begin
        match = 1'b0;
        sx    = '0;
        sy    = '0;
        for (int k = 0; k < MAX_SLOTS; k++) begin
            if (k < N_CELLS) begin
                sx = slot_x(pos_q, k);
                sy = slot_y(pos_q, k);
                if ((sx != '0) && (sy != '0) && (sx == cell_col) && (sy == cell_row)) begin
                    match = 1'b1;
                end
            end
        end
        hit     = in_grid && video_on_d1 && match && !hide;
        ship_d  = hit;
        rgb_d   = hit ? (edge_s1 ? EDGE_COLOR : SHIP_COLOR) : 8'h00;
        valid_d = video_on_d1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q   <= '0;
            ship_q  <= 1'b0;
            rgb_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            pos_q   <= pos_d;
            ship_q  <= ship_d;
            rgb_q   <= rgb_d;
            valid_q <= valid_d;
        end
    end

    assign bus.ship_pixel  = ship_q;
    assign bus.rgb         = rgb_q;
    assign bus.pixel_valid = valid_q;

endmodule

// File: tb/tb_vga_desenho_embarcacao.sv
// Bench for vga_desenho_embarcacao: directed plan plus random frames, scoreboarded against a pixel-level model.
module tb_vga_desenho_embarcacao;
    import vga_pkg::*;

    localparam int      N_CELLS   = 3;
    localparam int      CELL_LOG2 = 5;
    localparam int      CELL      = 1 << CELL_LOG2;
    localparam int      GRID_X0   = 64;
    localparam int      GRID_Y0   = 0;
    localparam rgb332_t SHIP      = 8'b100_100_10;
    localparam rgb332_t EDGE      = 8'b010_010_01;
    localparam int      W         = 42;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    vga_desenho_embarcacao_if bus();

    vga_desenho_embarcacao #(
        .N_CELLS    (N_CELLS),
        .CELL_LOG2  (CELL_LOG2),
        .GRID_X0    (GRID_X0),
        .GRID_Y0    (GRID_Y0),
        .SHIP_COLOR (SHIP),
        .EDGE_COLOR (EDGE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // scoreboard: {due cycle[31:0], pixel_valid, ship_pixel, rgb[7:0]}
    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [63:0] m_shadow = '0;
    int          m_frames = 0;
    logic [63:0] cur_vec  = '0;

    function automatic logic [9:0] model_out(int x, int y, bit von);
        int  col, row, ox, oy, sxv, syv;
        bit  hit, edg;
        hit = 0;
        edg = 0;
        if (von && x >= GRID_X0 && y >= GRID_Y0) begin
            col = (x - GRID_X0) / CELL + 1;
            row = (y - GRID_Y0) / CELL + 1;
            ox  = (x - GRID_X0) % CELL;
            oy  = (y - GRID_Y0) % CELL;
            edg = (ox == 0) || (ox == CELL - 1) || (oy == 0) || (oy == CELL - 1);
            if (col <= 15 && row <= 15) begin
                for (int k = 0; k < N_CELLS; k++) begin
                    sxv = int'((m_shadow >> (3 + 8 * k)) & 64'hF);
                    syv = int'((m_shadow >> (7 + 8 * k)) & 64'hF);
                    if (sxv != 0 && syv != 0 && sxv == col && syv == row) hit = 1;
                end
            end
        end
`ifdef VGA_EMBARCACAO_BLINK_EN
        if ((m_frames % 64) >= 32) hit = 0;
`endif
        return {von, hit, hit ? (edg ? EDGE : SHIP) : 8'h00};
    endfunction

    function automatic logic [63:0] mk_slot(int k, int x, int y);
        logic [63:0] v;
        v = (64'(x & 15) << (3 + 8 * k)) | (64'(y & 15) << (7 + 8 * k));
        return v;
    endfunction

    task automatic check(string name, logic [9:0] act, logic [9:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got valid/ship/rgb=%b/%b/%h expected %b/%b/%h",
                     name, cyc, act[9], act[8], act[7:0], exp[9], exp[8], exp[7:0]);
        end
    endtask

    // driver tasks
    task automatic drive(int x, int y, bit von, bit fs);
        @(negedge clk);
        bus.pixel_x            = 10'(x);
        bus.pixel_y            = 10'(y);
        bus.video_on           = von;
        bus.frame_start        = fs;
        bus.posicoesEmbarcacao = cur_vec;
        if (fs) begin
            m_shadow = cur_vec;
            m_frames = m_frames + 1;
        end
        exp_q.push_back({32'(cyc + 2), model_out(x, y, von)});
    endtask

    task automatic pix(int x, int y, bit von = 1'b1);
        drive(x, y, von, 1'b0);
    endtask

    task automatic frame(logic [63:0] vec);
        cur_vec = vec;
        drive(0, 0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset           = 1'b1;
        bus.frame_start = 1'b0;
        exp_q.delete();
        m_shadow = '0;
        m_frames = 0;
        @(posedge clk);
        #1;
        check("reset_outputs", {bus.pixel_valid, bus.ship_pixel, bus.rgb}, 10'h000);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // monitor: pops expected entry when its cycle is due
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0 && exp_q[0][41:10] == 32'(cyc)) begin
                e = exp_q.pop_front();
                check("pixel", {bus.pixel_valid, bus.ship_pixel, bus.rgb}, e[9:0]);
            end
        end
    end

    initial begin
        int x, y, k;
        logic [63:0] v;
        bus.pixel_x            = '0;
        bus.pixel_y            = '0;
        bus.video_on           = 1'b0;
        bus.frame_start        = 1'b0;
        bus.posicoesEmbarcacao = '0;

        do_reset();

        // empty vector: nothing across a subsampled frame
        frame(64'h0);
        for (int yy = 0; yy < 480; yy += 13)
            for (int xx = 0; xx < 640; xx += 7)
                pix(xx, yy);

        // single ship cell (1,1)
        frame(64'h88);
        pix(80, 16);
        pix(64, 0);
        pix(100, 16);

        // vector change without frame_start is not seen until the next frame
        cur_vec = 64'h90;
        pix(80, 16);
        pix(112, 16);
        frame(64'h90);
        pix(112, 16);
        pix(80, 16);

        // three slots, one unplaced, slot 3 and spare bits populated
        v = mk_slot(0, 1, 1) | mk_slot(1, 2, 1) | mk_slot(2, 0, 5) | mk_slot(3, 3, 1)
            | 64'h7 | (64'h1F << 59);
        frame(v);
        for (int c = 0; c < 6; c++) pix(GRID_X0 + c * CELL + 10, 16);
        for (int r = 1; r < 7; r++) pix(GRID_X0 + 10, (r - 1) * CELL + 10);

        // grid boundaries, duplicates and video_on low
        frame(mk_slot(0, 15, 1) | mk_slot(1, 1, 1) | mk_slot(2, 1, 1));
        pix(10, 16);
        pix(63, 16);
        pix(530, 16);
        pix(543, 16);
        pix(544, 16);
        pix(80, 16);
        pix(80, 16, 1'b0);
        pix(80, 15 * CELL + 5);

        // mid-frame reset while drawing
        pix(80, 16);
        pix(80, 16);
        do_reset();
        pix(80, 16);
        pix(530, 16);
        frame(mk_slot(0, 1, 1));
        pix(80, 16);

        // random frames, occasional mid-frame vector changes
        for (int f = 0; f < 30; f++) begin
            v = $urandom();
            v = {v[31:0], 32'($urandom())};
            for (int s = 0; s < MAX_SLOTS; s++)
                if ($urandom_range(0, 7) == 0) v = v & ~mk_slot(s, 15, 0);
            frame(v);
            for (int p = 0; p < 150; p++) begin
                if ($urandom_range(0, 1) == 0) begin
                    k = $urandom_range(0, N_CELLS - 1);
                    x = GRID_X0 + (int'((m_shadow >> (3 + 8 * k)) & 64'hF) - 1) * CELL
                        + $urandom_range(0, CELL - 1);
                    y = GRID_Y0 + (int'((m_shadow >> (7 + 8 * k)) & 64'hF) - 1) * CELL
                        + $urandom_range(0, CELL - 1);
                    if (x < 0) x = $urandom_range(0, 63);
                    if (y < 0) y = $urandom_range(0, 31);
                end else begin
                    x = $urandom_range(0, 1023);
                    y = $urandom_range(0, 1023);
                end
                if ($urandom_range(0, 49) == 0) cur_vec = {32'($urandom()), 32'($urandom())};
                pix(x, y, $urandom_range(0, 9) != 0);
            end
        end

        // long run of frames to exercise the blink period
        do_reset();
        for (int f = 0; f < 70; f++) begin
            frame(64'h88);
            pix(80, 16);
            pix(64, 16);
        end

        // drain
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d entries still pending, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_desenho_embarcacao.md
Name: vga_desenho_embarcacao

Overview:
- Downstream consumer of the 64-bit ship position vector produced by the coordinate/move stage.
- For every pixel the VGA timing generator scans, it decides whether that pixel lies inside an occupied ship cell and outputs the ship colour.
- Output feeds the VGA colour mux.
- The position vector is captured once per frame so a ship moved mid-frame never tears.

Parameters:
- N_CELLS, 1, number of occupied cells (ship length); legal 1..7; submarine = 1
- CELL_LOG2, 5, cell size = 2**CELL_LOG2 pixels square (32 px)
- GRID_X0, 64, pixel column of grid cell column 1 left edge
- GRID_Y0, 0, pixel row of grid cell row 1 top edge
- SHIP_COLOR, 8'b100_100_10, RGB332 fill colour
- EDGE_COLOR, 8'b010_010_01, RGB332 colour of the 1-pixel cell outline

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- pixel_x  in  10  current scan column
- pixel_y  in  10  current scan row
- video_on  in  1  high in visible area
- frame_start  in  1  one-cycle pulse at start of vertical blank
- posicoesEmbarcacao  in  64  packed cell coordinates from the coordinate stage
- ship_pixel  out  1  current (delayed) pixel belongs to the ship
- rgb  out  8  RGB332 colour; 0 when ship_pixel low
- pixel_valid  out  1  video_on delayed to align with rgb

Behaviour:
- Interface: one clock, clk; reset is synchronous, active-high, port named reset.
- Vector encoding, slot k = 0..6:
  - X = vec[3+8k +: 4], Y = vec[7+8k +: 4].
  - Bits [2:0] and [63:59] are ignored.
  - Coordinate value 0 = slot unplaced; legal values are 1..15.
  - A slot is active only if k < N_CELLS, X != 0 and Y != 0.
- Frame shadow:
  - pos_shadow (64 b) loads posicoesEmbarcacao on the cycle frame_start is high.
  - It holds at all other times.
  - Reset clears it to 0, so nothing is drawn until the first frame_start.
- Stage 1 (registered):
  - rel_x = pixel_x - GRID_X0, rel_y = pixel_y - GRID_Y0, computed 11-bit signed.
  - If either is negative, in_grid = 0.
  - Otherwise cell_col = (rel_x >> CELL_LOG2) + 1 and cell_row = (rel_y >> CELL_LOG2) + 1.
  - If cell_col or cell_row > 15, in_grid = 0.
  - Register the cell_col/cell_row low 4 bits, in_grid, edge flag, video_on.
  - Edge flag = in-cell offset (low CELL_LOG2 bits of rel_x or rel_y) equal to 0 or all-ones.
- Stage 2 (registered):
  - hit = in_grid & video_on_d1 & OR over active slots of (X == cell_col && Y == cell_row).
  - ship_pixel = hit.
  - rgb = hit ? (edge ? EDGE_COLOR : SHIP_COLOR) : 8'h00.
  - pixel_valid = video_on_d1.
- Latency: exactly 2 clk from pixel_x/pixel_y/video_on to outputs; fully pipelined, one pixel per cycle, no stalls.
- Reset values: ship_pixel = 0, rgb = 0, pixel_valid = 0, all pipeline registers = 0.
- Boundary conditions:
  - frame_start and a vector change in the same cycle: the new vector is captured.
  - Duplicate coordinates across slots: draw normally (OR).
  - Reset mid-frame: outputs are 0 on the next cycle; drawing resumes only after the next frame_start.

Optional Feature:
- Macro: VGA_EMBARCACAO_BLINK_EN.
- With the macro defined:
  - A 6-bit frame counter increments on each frame_start (wraps 63 -> 0) and is cleared by reset.
  - When counter bit 5 is 1, the stage-2 hit is forced 0 (ship hidden for 32 frames, shown for 32).
  - pixel_valid is unaffected.
- Without the macro: no counter exists and the ship is always drawn.

Decomposition:
- Shared package vga_pkg:
  - RGB332 type
  - constants COORD_W = 4, SLOT_STRIDE = 8, SLOT_BASE = 3, MAX_SLOTS = 7, GRID_MAX = 15
  - function extracting X/Y of slot k
- One natural sub-module: vga_celula_pixel (stage 1: pixel -> cell_col/cell_row/in_grid/edge), reusable by the cursor and hit-marker drawers.

Test Plan:
- Reset, then frame_start with vector = 64'h0 -> ship_pixel = 0, rgb = 0 across a full scanned frame.
- Vector with X = 1, Y = 1 (64'h88), frame_start, scan pixel (80,16) with video_on = 1 -> 2 cycles later ship_pixel = 1, rgb = SHIP_COLOR; pixel (64,0) -> rgb = EDGE_COLOR; pixel (100,16) -> rgb = 0.
- Change vector to X = 2, Y = 1 mid-frame with no frame_start -> pixel (80,16) still drawn; after frame_start, pixel (112,16) drawn and (80,16) not.
- N_CELLS = 3, slots (1,1),(2,1),(0,5) -> only columns 1-2 of row 1 drawn; slot with X = 0 ignored; slot 3 bits ignored even if nonzero.
- Pixel left of GRID_X0 (x = 10) and pixel beyond column 15 (x = 64+15*32) -> ship_pixel = 0; video_on = 0 on an in-ship pixel -> rgb = 0, pixel_valid = 0.
- Assert reset mid-frame while drawing -> outputs 0 next cycle; with VGA_EMBARCACAO_BLINK_EN, frames 0-31 drawn, frames 32-63 blank, frame 64 drawn again.
